// File: rtl/dino_game_pkg.sv
// Shared definitions for the dino game blocks.
// Holds the game-state encoding and the default playfield geometry.
// Also holds the packed-BCD score width and a small compare helper.
package dino_game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int DINO_X   = 80;   // left edge of dino box, pixels
  localparam int DINO_W   = 40;   // dino box width
  localparam int OBS_W    = 20;   // obstacle width
  localparam int OBS_H    = 40;   // minimum dino height that clears an obstacle
  localparam int SCREEN_W = 640;

  localparam int BCD_W = 16;
  localparam logic [BCD_W-1:0] SCORE_MAX = 16'h9999;

  // Packed BCD orders the same way as plain unsigned binary.
  function automatic logic [BCD_W-1:0] bcd_max(input logic [BCD_W-1:0] a,
                                               input logic [BCD_W-1:0] b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/bcd_incrementer.sv
// Combinational 4-digit packed-BCD adder of a small increment (0..2).
// The result saturates at 9999.
// Ports:
//   value_in  [15:0]  current packed-BCD value
//   inc       [1:0]   amount to add (0, 1 or 2)
//   value_out [15:0]  value_in + inc, clamped to 9999
module bcd_incrementer
  import dino_game_pkg::*;
(
  input  logic [BCD_W-1:0] value_in,
  input  logic [1:0]       inc,
  output logic [BCD_W-1:0] value_out
);

  // Ripple the increment through the four digits; bit 16 is the carry out of the top digit.
  function automatic logic [BCD_W:0] bcd_add(input logic [BCD_W-1:0] v,
                                             input logic [1:0]       n);
    logic [4:0]       carry;
    logic [4:0]       digit;
    logic [BCD_W-1:0] r;
    carry = {3'b000, n};
    r     = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      digit = {1'b0, v[i*4 +: 4]} + carry;
      if (digit > 5'd9) begin
        r[i*4 +: 4] = 4'(digit - 5'd10);
        carry       = 5'd1;
      end else begin
        r[i*4 +: 4] = digit[3:0];
        carry       = 5'd0;
      end
    end
    return {carry[0], r};
  endfunction

  logic [BCD_W:0] sum_s;

  // Add, and clamp to 9999 when the top digit carries out.
  always_comb begin
    sum_s = bcd_add(value_in, inc);
    if (sum_s[BCD_W]) begin
      value_out = SCORE_MAX;
    end else begin
      value_out = sum_s[BCD_W-1:0];
    end
  end

endmodule

// File: rtl/collision_scorer.sv
// Game-state controller for the dino game.
// On each game tick in RUN it checks both obstacles against the dino box,
// ends the game on a collision, and counts cleared obstacles as a BCD score.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   game_tick             one-cycle frame strobe
//   start                 one-cycle button pulse
//   obstacle_x1/x2 [9:0]  obstacle left edges
//   dino_h         [9:0]  dino height above ground
//   running               high in RUN (gates the obstacle generator)
//   game_over             high in OVER
//   obs_restart           one-cycle pulse restarting the obstacle generator
//   score_bcd      [15:0] current score, packed BCD
//   hi_score_bcd   [15:0] best score since reset, packed BCD
module collision_scorer
  import dino_game_pkg::*;
#(
  parameter int DINO_X = dino_game_pkg::DINO_X,
  parameter int DINO_W = dino_game_pkg::DINO_W,
  parameter int OBS_W  = dino_game_pkg::OBS_W,
  parameter int OBS_H  = dino_game_pkg::OBS_H
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_tick,
  input  logic        start,
  input  logic [9:0]  obstacle_x1,
  input  logic [9:0]  obstacle_x2,
  input  logic [9:0]  dino_h,
  output logic        running,
  output logic        game_over,
  output logic        obs_restart,
  output logic [15:0] score_bcd,
  output logic [15:0] hi_score_bcd
);

  // An obstacle overlaps when any of its columns falls inside the dino box.
  localparam logic [9:0] OVL_LO  = 10'(DINO_X - OBS_W + 1);
  localparam logic [9:0] OVL_HI  = 10'(DINO_X + DINO_W - 1);
  // An obstacle is cleared once its left edge crosses this threshold.
  localparam logic [9:0] PASS_X  = 10'(DINO_X - OBS_W);
  localparam logic [9:0] CLEAR_H = 10'(OBS_H);

  state_t           state_q, state_d;
  logic             running_q, running_d;
  logic             game_over_q, game_over_d;
  logic             obs_restart_q, obs_restart_d;
  logic [BCD_W-1:0] score_q, score_d;
  logic [BCD_W-1:0] hi_q, hi_d;
  logic [9:0]       prev_x1_q, prev_x1_d;
  logic [9:0]       prev_x2_q, prev_x2_d;
  logic             prev_valid_q, prev_valid_d;

  logic             ovl1_s, ovl2_s, collide_s;
  logic             pass1_s, pass2_s;
  logic [1:0]       inc_s;
  logic [BCD_W-1:0] score_inc_s;

  // Geometry checks; only meaningful on a RUN tick with prev_valid set.
  always_comb begin
    ovl1_s    = (obstacle_x1 >= OVL_LO) && (obstacle_x1 <= OVL_HI);
    ovl2_s    = (obstacle_x2 >= OVL_LO) && (obstacle_x2 <= OVL_HI);
    collide_s = (ovl1_s || ovl2_s) && (dino_h < CLEAR_H);
    // A reload jumps from a small x to a large one, so it never looks like a crossing.
    pass1_s   = (prev_x1_q >= PASS_X) && (obstacle_x1 < PASS_X);
    pass2_s   = (prev_x2_q >= PASS_X) && (obstacle_x2 < PASS_X);
    inc_s     = {1'b0, pass1_s} + {1'b0, pass2_s};
  end

  bcd_incrementer u_score_inc (
    .value_in  (score_q),
    .inc       (inc_s),
    .value_out (score_inc_s)
  );

  // Next-state logic; start wins over a tick in IDLE/OVER.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (game_tick && prev_valid_q && collide_s) begin
          state_d = OVER;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output values for the next cycle.
  always_comb begin
    score_d       = score_q;
    hi_d          = hi_q;
    prev_x1_d     = prev_x1_q;
    prev_x2_d     = prev_x2_q;
    prev_valid_d  = prev_valid_q;
    obs_restart_d = 1'b0;
    running_d     = (state_d == RUN);
    game_over_d   = (state_d == OVER);
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          score_d       = 16'h0000;
          prev_valid_d  = 1'b0;
          obs_restart_d = 1'b1;
        end else begin
          obs_restart_d = 1'b0;
        end
      end
      RUN: begin
        if (game_tick) begin
          prev_x1_d = obstacle_x1;
          prev_x2_d = obstacle_x2;
          if (!prev_valid_q) begin
            // First tick after entry only seeds the previous positions.
            prev_valid_d = 1'b1;
          end else if (collide_s) begin
            // Collision beats any pass on the same tick; score is frozen.
            hi_d = bcd_max(hi_q, score_q);
          end else begin
            score_d = score_inc_s;
          end
        end else begin
          prev_valid_d = prev_valid_q;
        end
      end
      default: begin
        score_d = score_q;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      running_q     <= 1'b0;
      game_over_q   <= 1'b0;
      obs_restart_q <= 1'b0;
      score_q       <= 16'h0000;
      hi_q          <= 16'h0000;
      prev_x1_q     <= 10'd0;
      prev_x2_q     <= 10'd0;
      prev_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      running_q     <= running_d;
      game_over_q   <= game_over_d;
      obs_restart_q <= obs_restart_d;
      score_q       <= score_d;
      hi_q          <= hi_d;
      prev_x1_q     <= prev_x1_d;
      prev_x2_q     <= prev_x2_d;
      prev_valid_q  <= prev_valid_d;
    end
  end

  assign running      = running_q;
  assign game_over    = game_over_q;
  assign obs_restart  = obs_restart_q;
  assign score_bcd    = score_q;
  assign hi_score_bcd = hi_q;

endmodule

// File: tb/tb_collision_scorer.sv
// Directed, table-driven bench for collision_scorer.
module tb_collision_scorer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        game_tick;
  logic        start;
  logic [9:0]  obstacle_x1;
  logic [9:0]  obstacle_x2;
  logic [9:0]  dino_h;
  logic        running;
  logic        game_over;
  logic        obs_restart;
  logic [15:0] score_bcd;
  logic [15:0] hi_score_bcd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  collision_scorer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .game_tick    (game_tick),
    .start        (start),
    .obstacle_x1  (obstacle_x1),
    .obstacle_x2  (obstacle_x2),
    .dino_h       (dino_h),
    .running      (running),
    .game_over    (game_over),
    .obs_restart  (obs_restart),
    .score_bcd    (score_bcd),
    .hi_score_bcd (hi_score_bcd)
  );

  typedef struct {
    logic        st;
    logic        tk;
    logic [9:0]  x1;
    logic [9:0]  x2;
    logic [9:0]  h;
    logic        e_run;
    logic        e_over;
    logic        e_rst;
    logic [15:0] e_score;
    logic [15:0] e_hi;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic tk, logic [9:0] x1, logic [9:0] x2,
                              logic [9:0] h, logic er, logic eo, logic ep,
                              logic [15:0] es, logic [15:0] eh);
    vec_t v;
    v.st = st; v.tk = tk; v.x1 = x1; v.x2 = x2; v.h = h;
    v.e_run = er; v.e_over = eo; v.e_rst = ep; v.e_score = es; v.e_hi = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic er, input logic eo, input logic ep,
                         input logic [15:0] es, input logic [15:0] eh);
    chk({tag, ".running"},     {15'd0, running},     {15'd0, er});
    chk({tag, ".game_over"},   {15'd0, game_over},   {15'd0, eo});
    chk({tag, ".obs_restart"}, {15'd0, obs_restart}, {15'd0, ep});
    chk({tag, ".score"},       score_bcd,            es);
    chk({tag, ".hi_score"},    hi_score_bcd,         eh);
  endtask

  // Drive one cycle of inputs, let the edge happen, then release the strobes.
  task automatic step(input logic st, input logic tk, input logic [9:0] x1,
                      input logic [9:0] x2, input logic [9:0] h);
    @(negedge clk);
    start = st; game_tick = tk; obstacle_x1 = x1; obstacle_x2 = x2; dino_h = h;
    @(posedge clk);
    #1;
    start = 1'b0; game_tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; game_tick = 1'b0;
    obstacle_x1 = 10'd540; obstacle_x2 = 10'd540; dino_h = 10'd0;

    //          st    tk    x1       x2       h       run   over  rst   score     hi
    vecs.push_back(mk(1'b0, 1'b1, 10'd100, 10'd540, 10'd0,  1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000)); // tick in IDLE ignored
    vecs.push_back(mk(1'b1, 1'b0, 10'd540, 10'd540, 10'd0,  1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000)); // start
    vecs.push_back(mk(1'b0, 1'b0, 10'd540, 10'd540, 10'd0,  1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000)); // pulse is one cycle
    vecs.push_back(mk(1'b1, 1'b0, 10'd540, 10'd540, 10'd0,  1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000)); // start in RUN ignored
    vecs.push_back(mk(1'b0, 1'b1, 10'd70,  10'd540, 10'd50, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000)); // first tick loads
    vecs.push_back(mk(1'b0, 1'b1, 10'd50,  10'd540, 10'd50, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000)); // pass
    vecs.push_back(mk(1'b0, 1'b1, 10'd540, 10'd540, 10'd50, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000)); // reload, no pass
    vecs.push_back(mk(1'b0, 1'b1, 10'd65,  10'd62,  10'd60, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000)); // overlap but high
    vecs.push_back(mk(1'b0, 1'b1, 10'd55,  10'd52,  10'd60, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000)); // double pass
    vecs.push_back(mk(1'b0, 1'b1, 10'd65,  10'd100, 10'd60, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000));
    vecs.push_back(mk(1'b0, 1'b1, 10'd55,  10'd90,  10'd0,  1'b0, 1'b1, 1'b0, 16'h0003, 16'h0003)); // collision beats pass
    vecs.push_back(mk(1'b0, 1'b1, 10'd50,  10'd540, 10'd0,  1'b0, 1'b1, 1'b0, 16'h0003, 16'h0003)); // tick in OVER ignored
    vecs.push_back(mk(1'b1, 1'b1, 10'd100, 10'd540, 10'd0,  1'b1, 1'b0, 1'b1, 16'h0000, 16'h0003)); // start+tick: start wins
    vecs.push_back(mk(1'b0, 1'b1, 10'd100, 10'd540, 10'd0,  1'b1, 1'b0, 1'b0, 16'h0000, 16'h0003)); // first tick: no collision
    vecs.push_back(mk(1'b0, 1'b1, 10'd61,  10'd540, 10'd39, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0003)); // low overlap edge
    vecs.push_back(mk(1'b1, 1'b0, 10'd540, 10'd540, 10'd0,  1'b1, 1'b0, 1'b1, 16'h0000, 16'h0003));
    vecs.push_back(mk(1'b0, 1'b1, 10'd60,  10'd540, 10'd0,  1'b1, 1'b0, 1'b0, 16'h0000, 16'h0003)); // load
    vecs.push_back(mk(1'b0, 1'b1, 10'd60,  10'd540, 10'd0,  1'b1, 1'b0, 1'b0, 16'h0000, 16'h0003)); // 60: no overlap, no pass
    vecs.push_back(mk(1'b0, 1'b1, 10'd59,  10'd540, 10'd0,  1'b1, 1'b0, 1'b0, 16'h0001, 16'h0003)); // 60 -> 59 passes
    vecs.push_back(mk(1'b0, 1'b1, 10'd120, 10'd540, 10'd0,  1'b1, 1'b0, 1'b0, 16'h0001, 16'h0003)); // 120: no overlap
    vecs.push_back(mk(1'b0, 1'b1, 10'd119, 10'd540, 10'd40, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0003)); // h=40 clears
    vecs.push_back(mk(1'b0, 1'b1, 10'd119, 10'd540, 10'd39, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0003)); // high overlap edge
    vecs.push_back(mk(1'b0, 1'b0, 10'd540, 10'd540, 10'd0,  1'b0, 1'b1, 1'b0, 16'h0001, 16'h0003)); // score held

    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].st, vecs[i].tk, vecs[i].x1, vecs[i].x2, vecs[i].h);
      chk_all($sformatf("vec%0d", i), vecs[i].e_run, vecs[i].e_over, vecs[i].e_rst,
              vecs[i].e_score, vecs[i].e_hi);
    end

    // Saturation: climb to 9998 two points at a time, then push past 9999.
    step(1'b1, 1'b0, 10'd540, 10'd540, 10'd0);
    step(1'b0, 1'b1, 10'd65, 10'd65, 10'd60);
    for (int p = 0; p < 4999; p++) begin
      step(1'b0, 1'b1, 10'd55, 10'd55, 10'd60);
      step(1'b0, 1'b1, 10'd65, 10'd65, 10'd60);
      if (p == 4) chk("sat.score10", score_bcd, 16'h0010);
      if (p == 49) chk("sat.score100", score_bcd, 16'h0100);
    end
    chk("sat.score9998", score_bcd, 16'h9998);
    step(1'b0, 1'b1, 10'd55, 10'd65, 10'd60);
    chk("sat.score9999", score_bcd, 16'h9999);
    step(1'b0, 1'b1, 10'd65, 10'd65, 10'd60);
    step(1'b0, 1'b1, 10'd55, 10'd55, 10'd60);
    chk("sat.plus2", score_bcd, 16'h9999);
    step(1'b0, 1'b1, 10'd65, 10'd65, 10'd60);
    step(1'b0, 1'b1, 10'd55, 10'd65, 10'd60);
    chk("sat.plus1", score_bcd, 16'h9999);
    step(1'b0, 1'b1, 10'd100, 10'd540, 10'd0);
    chk_all("sat.collide", 1'b0, 1'b1, 1'b0, 16'h9999, 16'h9999);
    step(1'b1, 1'b0, 10'd540, 10'd540, 10'd0);
    chk_all("sat.restart", 1'b1, 1'b0, 1'b1, 16'h0000, 16'h9999);

    // Asynchronous reset mid-RUN, checked before any clock edge.
    step(1'b0, 1'b1, 10'd70, 10'd540, 10'd50);
    step(1'b0, 1'b1, 10'd50, 10'd540, 10'd50);
    chk("pre_rst.score", score_bcd, 16'h0001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    chk_all("held_rst", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
